mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported RAM between the datapath instruction fetch (iREN)
//  and data access (dREN/dWEN) request streams. Sits between the datapath's
//  request unit and RAM. Sequences each access through a grant/busy/response FSM.
//  Data accesses have priority; a starvation counter bounds how long fetch can
//  wait behind back-to-back data traffic.
// PARAMETERS
//  STARVE_LIMIT  4   max consecutive data grants issued while iREN is pending;
//                    the next contested grant goes to fetch (range 1..15)
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   reset, asynchronous, active-low
//  iREN       in   1   instruction read request (hold until ihit)
//  iaddr      in   32  instruction address
//  ihit       out  1   1-cycle pulse: fetch complete, iload valid
//  iload      out  32  fetched instruction word (registered)
//  dREN       in   1   data read request (hold until dhit)
//  dWEN       in   1   data write request (hold until dhit)
//  daddr      in   32  data address
//  dstore     in   32  write data
//  dhit       out  1   1-cycle pulse: data access complete
//  dload      out  32  read data (registered)
//  ramREN     out  1   RAM read strobe
//  ramWEN     out  1   RAM write strobe
//  ramaddr    out  32  RAM address
//  ramstore   out  32  RAM write data
//  ramload    in   32  RAM read data, valid when ramready=1
//  ramready   in   1   RAM completes current access this cycle
// BEHAVIOUR
//  States: IDLE, I_BUSY, D_BUSY, RESP. Reset -> IDLE; ihit=dhit=0,
//  iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, starve count=0.
//  IDLE: sample requests. dreq = dREN|dWEN.
//   - dreq & ~iREN -> D_BUSY;  iREN & ~dreq -> I_BUSY;  none -> stay IDLE.
//   - both: if count==STARVE_LIMIT -> I_BUSY, else -> D_BUSY.
//   - on grant, latch address (and dstore, op) into internal regs.
//  Starve count: +1 on D grant while iREN=1 (saturate at STARVE_LIMIT);
//   cleared on I grant or on D grant with iREN=0.
//  dREN&dWEN both high: treated as write; dload unchanged.
//  I_BUSY: ramREN=1, ramaddr=latched iaddr. D_BUSY: ramREN or ramWEN per
//   latched op, ramaddr/ramstore from latched regs. Strobes held steady until
//   ramready. Input changes during BUSY are ignored (latched copy used).
//  ramready in BUSY: capture ramload into iload (I) or dload (D read); -> RESP.
//  ramready outside BUSY: ignored.
//  RESP (1 cycle): ihit or dhit =1 per finished access, all RAM strobes 0;
//   -> IDLE. No arbitration in RESP; requester updates requests on the edge
//   ending RESP.
//  Latency: request seen in IDLE at cycle t -> strobes at t+1; ramready at
//   cycle t+k (k>=1) -> hit at t+k+1. Min request-to-hit = 3 cycles.
//  Request dropped mid-access: access still completes, hit still pulses.
//  nRST low at any time: immediate return to reset values; RAM strobes
//   drop asynchronously; in-flight access abandoned, no hit issued.
//  ihit and dhit never both 1; ramREN and ramWEN never both 1.
// TESTING
//  1 iREN=1 iaddr=0x40, RAM ready after 2 cycles with 0x8C220004 ->
//    ramREN/ramaddr=0x40 held 2 cycles, ihit pulse 1 cycle, iload=0x8C220004.
//  2 iREN and dREN same cycle, daddr=0x100 -> D granted first (ramaddr=0x100),
//    dhit, then I granted; ihit follows.
//  3 iREN held, dWEN re-asserted every IDLE, STARVE_LIMIT=4 -> exactly 4
//    writes, then 1 fetch, count back to 0.
//  4 dREN=dWEN=1 daddr=0x20 dstore=0xDEADBEEF -> ramWEN=1, ramREN=0,
//    ramstore=0xDEADBEEF; dload unchanged after dhit.
//  5 change daddr 0x20->0x24 during D_BUSY -> ramaddr stays 0x20.
//  6 nRST low during I_BUSY -> ramREN=0 at once, no ihit; after release
//    state IDLE, count=0, next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction fetch
// stream and the data access stream. Each access runs through
// IDLE -> grant -> BUSY (strobes held until ramready) -> RESP (hit pulse).
// Data accesses win contested grants, but once STARVE_LIMIT data grants have
// been issued back to back while fetch was waiting, the next contested grant
// goes to fetch.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction fetch side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  // data access side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  // Starvation counter is 4 bits wide, enough for limits up to 15.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Latched copy of the granted request; the RAM is driven only from these,
  // so requester inputs may change freely while an access is in flight.
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic        r_wr;
  logic        r_is_d;

  logic [3:0]  r_count;
  logic [31:0] r_iload;
  logic [31:0] r_dload;

  logic        w_dreq;
  logic        w_grant_i;
  logic        w_grant_d;

  // Saturating increment of the starvation counter, clamped at LIMIT.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    if (c >= LIMIT) begin
      return LIMIT;
    end
    return c + 4'd1;
  endfunction

  assign w_dreq = dREN | dWEN;
  assign iload  = r_iload;
  assign dload  = r_dload;

  // State register; async reset drops strobes immediately and abandons any access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbitration, next-state and RAM/hit outputs, all decoded from the current state.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    case (r_state)
      IDLE: begin
        // Data wins unless fetch is also waiting and has hit the starvation limit.
        if (w_dreq && !(iREN && (r_count == LIMIT))) begin
          w_grant_d = 1'b1;
          w_next    = D_BUSY;
        end else if (iREN) begin
          w_grant_i = 1'b1;
          w_next    = I_BUSY;
        end
      end
      I_BUSY: begin
        ramREN  = 1'b1;
        ramaddr = r_addr;
        if (ramready) begin
          w_next = RESP;
        end
      end
      D_BUSY: begin
        ramREN  = !r_wr;
        ramWEN  = r_wr;
        ramaddr = r_addr;
        if (r_wr) begin
          ramstore = r_store;
        end
        if (ramready) begin
          w_next = RESP;
        end
      end
      RESP: begin
        // One-cycle completion pulse; no arbitration here so the requester
        // can retire the finished request on the edge ending this cycle.
        ihit   = !r_is_d;
        dhit   = r_is_d;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Capture the granted request; a combined dREN+dWEN request is a write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
      r_is_d  <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= daddr;
      r_store <= dstore;
      r_wr    <= dWEN;
      r_is_d  <= 1'b1;
    end else if (w_grant_i) begin
      r_addr  <= iaddr;
      r_wr    <= 1'b0;
      r_is_d  <= 1'b0;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (w_grant_d) begin
      r_count <= iREN ? sat_inc(r_count) : 4'd0;
    end else if (w_grant_i) begin
      r_count <= '0;
    end
  end

  // Register RAM read data on completion; ramready outside BUSY is ignored.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_iload <= '0;
      r_dload <= '0;
    end else if (ramready) begin
      if (r_state == I_BUSY) begin
        r_iload <= ramload;
      end else if ((r_state == D_BUSY) && !r_wr) begin
        r_dload <= ramload;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester model, RAM stub with random
// latency, reference arbitration model feeding two scoreboard queues.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
  } ram_txn_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } hit_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          abort    = 0;
  bit          hold_ready = 0;

  ram_txn_t    exp_ram_q[$];
  hit_t        exp_hit_q[$];
  bit          seq[$];

  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_dload;
  int          ref_count;

  // requester state
  bit          ip;
  bit          dp;
  logic [31:0] ia;
  logic [31:0] da;
  logic [31:0] ds;
  int          dop;   // 0 read, 1 write, 2 both strobes (write)

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic new_i();
    ip = 1'b1;
    ia = rand_addr();
  endtask

  task automatic new_d(input int op);
    dp  = 1'b1;
    da  = rand_addr();
    ds  = $urandom;
    dop = op;
  endtask

  task automatic drive_inputs();
    iREN   = ip;
    iaddr  = ia;
    dREN   = dp && (dop != 1);
    dWEN   = dp && (dop != 0);
    daddr  = da;
    dstore = ds;
  endtask

  // Reference arbitration: decides the winner of the pending set, updates the
  // starvation count and model memory, and queues the expected RAM access and hit.
  function automatic bit model_grant();
    bit       g_d;
    ram_txn_t t;
    hit_t     h;
    if (ip && dp) g_d = (ref_count < LIMIT);
    else          g_d = dp;
    if (g_d) begin
      if (ip) ref_count = (ref_count < LIMIT) ? ref_count + 1 : LIMIT;
      else    ref_count = 0;
      t.wr    = (dop != 0);
      t.addr  = da;
      t.store = ds;
      if (t.wr) ref_mem[da[5:2]] = ds;
      else      ref_dload = ref_mem[da[5:2]];
      h.is_d = 1'b1;
      h.data = ref_dload;
    end else begin
      ref_count = 0;
      t.wr    = 1'b0;
      t.addr  = ia;
      t.store = '0;
      h.is_d  = 1'b0;
      h.data  = ref_mem[ia[5:2]];
    end
    exp_ram_q.push_back(t);
    exp_hit_q.push_back(h);
    return g_d;
  endfunction

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_msg("strobe_timeout", "no RAM strobe within 10 cycles");
      abort = 1'b1;
    end
  endtask

  task automatic wait_hit(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_msg("hit_timeout", "no ihit/dhit within 20 cycles");
      abort = 1'b1;
    end
  endtask

  // Perturb the in-flight stream's inputs; the DUT must keep using its latched copy.
  task automatic scramble(input bit g_d);
    if (g_d) begin
      daddr  = rand_addr();
      dstore = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        dREN = 1'b0;
        dWEN = 1'b0;
      end
    end else begin
      iaddr = rand_addr();
      if ($urandom_range(0, 3) == 0) iREN = 1'b0;
    end
  endtask

  // Issue n accesses. starve=1: fetch held and a data write re-raised after
  // every completion. Hit types (1 = data) are recorded in seq.
  task automatic run_accesses(input int n, input bit starve);
    bit ok;
    bit g_d;
    seq.delete();
    for (int k = 0; k < n && !abort; k++) begin
      if (!ip && !dp) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        if (starve) begin
          new_i();
          new_d(1);
        end else begin
          case ($urandom_range(0, 2))
            0:       new_i();
            1:       new_d(int'($urandom_range(0, 2)));
            default: begin new_i(); new_d(int'($urandom_range(0, 2))); end
          endcase
        end
        drive_inputs();
      end
      g_d = model_grant();
      wait_strobe(ok);
      if (!ok) return;
      if (!starve && ($urandom_range(0, 1) == 1)) scramble(g_d);
      wait_hit(ok);
      if (!ok) return;
      seq.push_back(dhit);
      if (g_d) dp = 1'b0;
      else     ip = 1'b0;
      if (starve) begin
        if (!ip) new_i();
        if (!dp) new_d(1);
      end else begin
        if (!dp && ($urandom_range(0, 3) != 0)) new_d(int'($urandom_range(0, 2)));
        if (!ip && ($urandom_range(0, 1) == 1)) new_i();
      end
      drive_inputs();
    end
    ip = 1'b0;
    dp = 1'b0;
    drive_inputs();
  endtask

  // Pull nRST low mid-access, check everything returns to reset values at once,
  // then clear the model (the abandoned access produces no hit).
  task automatic do_reset(input string tag);
    #2 nRST = 1'b0;
    #1;
    check1({tag, "_ramREN"}, ramREN, 1'b0);
    check1({tag, "_ramWEN"}, ramWEN, 1'b0);
    check32({tag, "_ramaddr"}, ramaddr, 32'h0);
    check1({tag, "_ihit"}, ihit, 1'b0);
    check1({tag, "_dhit"}, dhit, 1'b0);
    check32({tag, "_dload"}, dload, 32'h0);
    check32({tag, "_iload"}, iload, 32'h0);
    ip = 1'b0;
    dp = 1'b0;
    drive_inputs();
    exp_ram_q.delete();
    exp_hit_q.delete();
    ref_count = 0;
    ref_dload = '0;
    @(negedge CLK);
    nRST = 1'b1;
    hold_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check1({tag, "_no_hit_after"}, ihit | dhit, 1'b0);
    end
  endtask

  task automatic check_starve_pattern(input string tag, input int n);
    check32({tag, "_len"}, 32'(seq.size()), 32'(n));
    for (int j = 0; j < seq.size(); j++) begin
      check1($sformatf("%s_%0d", tag, j), seq[j], ((j % (LIMIT + 1)) != LIMIT));
    end
  endtask

  // RAM stub: random latency 1..3 cycles, random ramready/ramload noise while
  // idle, checks each access against the expected queue and that strobes hold.
  initial begin
    bit       active;
    int       lat;
    int       cnt;
    ram_txn_t cur;
    ram_txn_t e;
    active   = 1'b0;
    lat      = 1;
    cnt      = 0;
    ramready = 1'b0;
    ramload  = '0;
    forever begin
      @(negedge CLK);
      if (!nRST || !(ramREN || ramWEN)) begin
        active   = 1'b0;
        ramready = nRST ? 1'($urandom_range(0, 1)) : 1'b0;
        ramload  = $urandom;
      end else begin
        check1("strobe_excl", ramREN & ramWEN, 1'b0);
        if (!active) begin
          active    = 1'b1;
          cnt       = 0;
          lat       = int'($urandom_range(1, 3));
          cur.wr    = ramWEN;
          cur.addr  = ramaddr;
          cur.store = ramstore;
          if (exp_ram_q.size() == 0) begin
            fail_msg("ram_unexpected", $sformatf("access addr 0x%08h with none expected", ramaddr));
          end else begin
            e = exp_ram_q.pop_front();
            check1("ram_wen", ramWEN, e.wr);
            check1("ram_ren", ramREN, !e.wr);
            check32("ram_addr", ramaddr, e.addr);
            if (e.wr) check32("ram_store", ramstore, e.store);
          end
        end else begin
          check1("hold_wen", ramWEN, cur.wr);
          check32("hold_addr", ramaddr, cur.addr);
          if (cur.wr) check32("hold_store", ramstore, cur.store);
        end
        cnt++;
        if (!hold_ready && cnt >= lat) begin
          ramready = 1'b1;
          if (ramWEN) begin
            ram_mem[ramaddr[5:2]] = ramstore;
            ramload = $urandom;
          end else begin
            ramload = ram_mem[ramaddr[5:2]];
          end
          active = 1'b0;
        end else begin
          ramready = 1'b0;
          ramload  = $urandom;
        end
      end
    end
  end

  // Hit monitor: pops the expected completion whenever a hit pulse appears.
  initial begin
    hit_t h;
    forever begin
      @(negedge CLK);
      if (nRST && (ihit || dhit)) begin
        check1("hit_excl", ihit & dhit, 1'b0);
        if (exp_hit_q.size() == 0) begin
          fail_msg("hit_unexpected", $sformatf("ihit=%b dhit=%b with none expected", ihit, dhit));
        end else begin
          h = exp_hit_q.pop_front();
          check1("hit_is_d", dhit, h.is_d);
          if (h.is_d) check32("dload", dload, h.data);
          else        check32("iload", iload, h.data);
        end
      end
    end
  end

  initial begin
    bit          ok;
    logic [31:0] v;
    nRST = 1'b1;
    hold_ready = 1'b0;
    ip = 1'b0;
    dp = 1'b0;
    ia = '0;
    da = '0;
    ds = '0;
    dop = 0;
    drive_inputs();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ref_count = 0;
    ref_dload = '0;

    #2 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    check1("rst_ihit", ihit, 1'b0);
    check1("rst_dhit", dhit, 1'b0);
    check32("rst_iload", iload, 32'h0);
    check32("rst_dload", dload, 32'h0);
    check1("rst_ramREN", ramREN, 1'b0);
    check1("rst_ramWEN", ramWEN, 1'b0);
    check32("rst_ramaddr", ramaddr, 32'h0);
    check32("rst_ramstore", ramstore, 32'h0);
    nRST = 1'b1;
    @(negedge CLK);

    // fetch held, writes re-raised: LIMIT writes then one fetch, repeating
    run_accesses(2 * (LIMIT + 1), 1'b1);
    if (!abort) check_starve_pattern("starve", 2 * (LIMIT + 1));

    if (!abort) run_accesses(80, 1'b0);

    // reset while a fetch is stalled in the RAM
    if (!abort) begin
      hold_ready = 1'b1;
      new_i();
      drive_inputs();
      void'(model_grant());
      wait_strobe(ok);
      if (ok) begin
        check1("rsti_pre_ren", ramREN, 1'b1);
        check32("rsti_pre_addr", ramaddr, ia);
        do_reset("rsti");
      end
    end

    // reset with the starvation count at its limit must clear the count
    if (!abort) run_accesses(LIMIT - 1, 1'b1);
    if (!abort) begin
      hold_ready = 1'b1;
      new_i();
      new_d(2);
      drive_inputs();
      void'(model_grant());
      wait_strobe(ok);
      if (ok) begin
        check1("rstd_pre_wen", ramWEN, 1'b1);
        check1("rstd_pre_ren", ramREN, 1'b0);
        check32("rstd_pre_store", ramstore, ds);
        do_reset("rstd");
      end
    end
    if (!abort) run_accesses(LIMIT + 1, 1'b1);
    if (!abort) check_starve_pattern("post_rst_starve", LIMIT + 1);

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
